// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO of {pc, instr, take}.
// Latency: an accepted push is visible at the head one cycle later (no bypass).
// Backpressure: in_ready = not full (independent of out_ready); flush empties in one cycle.
module if_id_queue #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int DEPTH      = 4,
  parameter logic [INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_SIZE-1:0]        in_pc,
  input  logic [INSTR_SIZE-1:0]     in_instr,
  input  logic                      in_take,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_SIZE-1:0]        out_pc,
  output logic [INSTR_SIZE-1:0]     out_instr,
  output logic                      out_take,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [PC_SIZE-1:0]    pc_mem    [DEPTH];
  logic [INSTR_SIZE-1:0] instr_mem [DEPTH];
  logic                  take_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Readiness depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is read straight from storage; masked to a NOP bubble when empty.
  always_comb begin
    out_pc    = '0;
    out_instr = INSTR_NOP;
    out_take  = 1'b0;
    if (out_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
      out_take  = take_mem[rd_ptr];
    end
  end

  // Entry storage: written on an accepted push that is not being discarded; never reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      take_mem[wr_ptr]  <= in_take;
    end
  end

  // Pointers and occupancy; reset outranks flush, flush drops any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_take = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_take;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  logic model_on = 1'b0;
  logic seen200 = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } ent_t;
  ent_t q[$];

  if_id_queue #(.PC_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH), .INSTR_NOP(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_take(in_take),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_take(out_take),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO queue updated on each rising edge.
  always @(posedge clk) begin
    ent_t e;
    logic do_push;
    logic do_pop;
    if (rst || flush) begin
      q.delete();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = in_pc; e.instr = in_instr; e.take = in_take;
        q.push_back(e);
      end
    end
    model_on <= 1'b1;
  end

  // Every-cycle comparison of all outputs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (q.size() != 0) begin
        chk("m_out_pc", out_pc, q[0].pc);
        chk("m_out_instr", out_instr, q[0].instr);
        chk("m_out_take", 32'(out_take), 32'(q[0].take));
      end else begin
        chk("m_out_pc", out_pc, 32'h0);
        chk("m_out_instr", out_instr, NOP);
        chk("m_out_take", 32'(out_take), 32'h0);
      end
      if (out_valid && out_pc == 32'h200) seen200 <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_instr = 32'h0010_0093 ^ (pc << 8);
    in_take  = pc[2];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with in_valid high: nothing stored.
    rst = 1'b1;
    drive(1'b1, 32'hAAA0);
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    drive(1'b0, 32'h0);
    step();
    chk("rst_nothing_stored", 32'(count), 32'd0);

    // 2. Fill, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i));
      step();
    end
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * i));
      step();
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // 3. Streaming through two pointer wraps.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i));
      step();
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_pc", out_pc, 32'h100 + 32'(4 * i));
    end
    drive(1'b0, 32'h0);
    step();
    chk("stream_empty", 32'(count), 32'd0);

    // 4. Flush with a simultaneous push.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'h200);
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_pc", out_pc, 32'h0);
    drive(1'b1, 32'h500);
    step();
    drive(1'b0, 32'h0);
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_pc", out_pc, 32'h500);
    out_ready = 1'b1;
    step();
    chk("pc200_absent", 32'(seen200), 32'd0);

    // 5. Stall stability with one extra push.
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h0050_0093; in_take = 1'b0;
    step();
    drive(1'b1, 32'h44);
    step();
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_pc", out_pc, 32'h40);
      chk("stall_instr", out_instr, 32'h0050_0093);
      chk("stall_count", 32'(count), 32'd2);
      step();
    end
    out_ready = 1'b1;
    step(); step();
    chk("stall_drained", 32'(count), 32'd0);

    // 6. Full with same-cycle pop: push refused this cycle, accepted next.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i));
      step();
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h700);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_in_ready_next", 32'(in_ready), 32'd1);
    step();
    chk("full_push_count", 32'(count), 32'd3);
    drive(1'b0, 32'h0);
    chk("full_head0", out_pc, 32'h608);
    step();
    chk("full_head1", out_pc, 32'h60C);
    step();
    chk("full_head2", out_pc, 32'h700);
    step();
    chk("full_empty", 32'(out_valid), 32'd0);

    // 7. Reset mid-operation behaves like flush.
    out_ready = 1'b0;
    drive(1'b1, 32'h800); step();
    drive(1'b1, 32'h804); step();
    rst = 1'b1;
    drive(1'b1, 32'h808);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_instr", out_instr, NOP);
    step();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. It buffers fetched {pc, instr, take} triples in a small circular FIFO, so fetch keeps running while decode stalls. It presents the oldest entry to decode through a valid/ready handshake. A flush on branch-mispredict or jalr redirect discards every buffered entry in one cycle.

## Interface
- `PC_SIZE`, 32, width of the pc field.
- `INSTR_SIZE`, 32, width of the instruction field.
- `DEPTH`, 4, number of entries; must be a power of two and at least 2.
- `INSTR_NOP`, 32'h0000_0013, instruction driven on `out_instr` when the queue is empty.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  discard all entries (`predict_fail` or `id_jalr` redirect).
- `in_valid`  in  1  fetch presents an entry.
- `in_ready`  out  1  queue can accept an entry.
- `in_pc`  in  PC_SIZE  pc of the fetched instruction.
- `in_instr`  in  INSTR_SIZE  fetched instruction.
- `in_take`  in  1  predecode predicted-taken flag.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head.
- `out_pc`  out  PC_SIZE  head pc.
- `out_instr`  out  INSTR_SIZE  head instruction.
- `out_take`  out  1  head predicted-taken flag.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is DEPTH entries of {pc, instr, take}.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH. A separate `count` register tracks occupancy and distinguishes full from empty.
- Push: fires when `in_valid && in_ready`. It writes entry[wr_ptr] and advances wr_ptr by 1.
- Pop: fires when `out_valid && out_ready`. It advances rd_ptr by 1.
- Readiness: `in_ready = (count != DEPTH)`. It does not depend on a same-cycle pop, so there is no combinational path from `out_ready` to `in_ready`.
- Validity: `out_valid = (count != 0)`.
- Head outputs:
  - `out_pc`, `out_instr` and `out_take` are read combinationally from entry[rd_ptr].
  - When the queue is empty, `out_instr = INSTR_NOP`, `out_take = 0` and `out_pc = 0`.
- Count update when push and pop happen in the same cycle:
  - Both fire: count is unchanged and both pointers advance.
  - Push only: count + 1.
  - Pop only: count − 1.
- Flush:
  - Next state is wr_ptr = rd_ptr = 0 and count = 0.
  - A same-cycle push is dropped.
  - A same-cycle pop is irrelevant. Decode must ignore that head, because flush is sourced from a later stage.
- Reset has priority over flush. Reset values: pointers 0, count 0, out_valid 0, in_ready 1, out_instr INSTR_NOP, out_take 0, out_pc 0.
- Entry storage contents are not reset. Outputs are masked by count == 0.
- Overflow and underflow cannot occur by construction:
  - A push when full is not accepted because in_ready = 0.
  - A pop when empty is not performed because out_valid = 0.

## Timing
- Latency from an accepted push to that entry appearing at the head of an empty queue: 1 cycle. The entry is visible the cycle after the push edge, with no same-cycle bypass.
- Throughput is 1 entry per cycle in and 1 out, sustained while 0 < count < DEPTH.
- At full with `out_ready = 1`: the pop happens this cycle, and in_ready rises the next cycle. The result is one bubble per full-to-draining transition.
- Flush asserted in cycle N: in cycle N+1, out_valid = 0, in_ready = 1 and count = 0. A push in cycle N+1 appears at the head in cycle N+2.
- Reset asserted mid-operation has the same effect as flush on the next edge.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. FIFO ordering is preserved across the wrap.
- Handshake rules:
  - While `in_valid && !in_ready`, fetch holds its inputs stable.
  - The head outputs stay stable while `out_valid && !out_ready`.

## Test plan
1. **Reset:** assert rst for 2 cycles with in_valid = 1 → count = 0, out_valid = 0, out_instr = 32'h13, in_ready = 1; no entry is stored.
2. **Fill and drain:** hold out_ready = 0 and push pc 0x0, 0x4, 0x8, 0xC → in_ready = 0 after the 4th push and count = 4. Then set out_ready = 1 → out_pc sequence is 0x0, 0x4, 0x8, 0xC, and out_valid drops after the last pop.
3. **Streaming with wrap:** in_valid = 1 and out_ready = 1 for 10 cycles with pc incrementing by 4 from 0x100 → count stays at 1 after the first cycle. out_pc lags in_pc by one cycle through two pointer wraps.
4. **Flush with simultaneous push:** with 3 entries queued, assert flush together with in_valid = 1 (pc 0x200) → next cycle count = 0 and out_valid = 0; pc 0x200 never appears at the output.
5. **Stall stability:** with the head at pc 0x40 and instr 0x00500093, hold out_ready = 0 for 5 cycles while pushing one entry → the head is unchanged and count increments once.
6. **Full with same-cycle pop:** at count = 4, set out_ready = 1 and in_valid = 1 → the push is not accepted that cycle (in_ready = 0), count becomes 3, and the push is accepted on the next cycle.
